// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: instruction and data memory handshakes for the
// multicycle sequencer. The sequencer is the master; the memories are the slave.
interface multicycle_sequencer_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: steps each instruction through FETCH/DECODE/EXECUTE/
// MEM/WB, owns the PC and IR, and drives the datapath enables. Memory accesses
// use valid/ready handshakes, so wait states simply hold the current state.
// Optional feature macro: MC_PERF_COUNTERS_EN adds perf_cycle/perf_instret.
module multicycle_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_sequencer_if.master mem,
  output logic [31:0]            instr,
  output logic [XLEN-1:0]        pc,
  output logic [XLEN-1:0]        pc_plus4,
  input  logic [XLEN-1:0]        alu_res,
  input  logic                   branch_taken,
  output logic                   ru_wr,
  output logic                   retire,
  output logic                   halted,
  output logic                   trap,
  output logic [2:0]             state
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [63:0]            perf_cycle,
  output logic [63:0]            perf_instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5,
    S_TRAP    = 3'd6
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0]     IR_NOP  = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, jump_target;
  logic [31:0]     ir_q;
  logic            pc_load, ir_load;
  logic            imem_req_c, dmem_req_c, dmem_we_c;
  logic [6:0]      opcode;
  logic            is_load, is_store, is_branch, is_jal, is_jalr, is_system;
  logic            opc_legal, sys_halt, rd_nonzero, br_bad, jump_bad;

  // Instruction classification works straight off the IR, which is stable
  // from DECODE until the next FETCH completes.
  assign opcode      = ir_q[6:0];
  assign is_load     = (opcode == OPC_LOAD);
  assign is_store    = (opcode == OPC_STORE);
  assign is_branch   = (opcode == OPC_BRANCH);
  assign is_jal      = (opcode == OPC_JAL);
  assign is_jalr     = (opcode == OPC_JALR);
  assign is_system   = (opcode == OPC_SYSTEM);
  assign opc_legal   = is_load | is_store | is_branch | is_jal | is_jalr | is_system |
                       (opcode == OPC_OP) | (opcode == OPC_OPIMM) |
                       (opcode == OPC_LUI) | (opcode == OPC_AUIPC);
  assign sys_halt    = (ir_q[31:7] == 25'h0000000) || (ir_q[31:7] == 25'h0002000);
  assign rd_nonzero  = (ir_q[11:7] != 5'd0);
  assign br_bad      = branch_taken && (alu_res[1:0] != 2'b00);
  assign jump_target = is_jalr ? {alu_res[XLEN-1:1], 1'b0} : alu_res;
  assign jump_bad    = (is_jal || is_jalr) && jump_target[1];

  assign pc_plus4      = pc_q + PC_STEP;
  assign pc            = pc_q;
  assign instr         = ir_q;
  assign state         = state_q;
  assign halted        = (state_q == S_HALT);
  assign trap          = (state_q == S_TRAP);
  assign mem.imem_req  = imem_req_c;
  assign mem.imem_addr = pc_q;
  assign mem.dmem_req  = dmem_req_c;
  assign mem.dmem_we   = dmem_we_c;

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic: wait states hold FETCH/MEM, HALT and TRAP are terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem.imem_ready) state_d = S_DECODE;
      S_DECODE:  state_d = opc_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)      state_d = br_bad ? S_TRAP : S_FETCH;
        else if (is_system)      state_d = sys_halt ? S_HALT : S_TRAP;
        else                     state_d = S_WB;
      end
      S_MEM:     if (mem.dmem_ready) state_d = is_store ? S_FETCH : S_WB;
      S_WB:      state_d = jump_bad ? S_TRAP : S_FETCH;
      default:   state_d = state_q;
    endcase
  end

  // Output logic: memory requests, write/retire strobes and PC/IR load enables.
  always_comb begin
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ru_wr      = 1'b0;
    retire     = 1'b0;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    pc_d       = pc_plus4;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        ir_load    = mem.imem_ready;
      end
      S_EXECUTE: begin
        if (is_branch && !br_bad) begin
          retire  = 1'b1;
          pc_load = 1'b1;
          pc_d    = branch_taken ? alu_res : pc_plus4;
        end else if (is_system && sys_halt) begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        if (mem.dmem_ready && is_store) begin
          retire  = 1'b1;
          pc_load = 1'b1;
        end
      end
      S_WB: begin
        if (!jump_bad) begin
          ru_wr   = rd_nonzero;
          retire  = 1'b1;
          pc_load = 1'b1;
          if (is_jal || is_jalr) pc_d = jump_target;
        end
      end
      default: ;
    endcase
  end

  // PC and IR registers; the IR resets to a NOP so the decoder sees a legal word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
      ir_q <= IR_NOP;
    end else begin
      if (ir_load) ir_q <= mem.imem_rdata;
      if (pc_load) pc_q <= pc_d;
    end
  end

`ifdef MC_PERF_COUNTERS_EN
  // Cycle counter runs until a terminal state; instret counts retire pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cycle   <= 64'd0;
      perf_instret <= 64'd0;
    end else begin
      if (!halted && !trap) perf_cycle <= perf_cycle + 64'd1;
      if (retire)           perf_instret <= perf_instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed and randomized checks of the multicycle
// sequencer against a rule-level model of per-class latency, writes and next PC.
module tb_multicycle_sequencer;

  localparam logic [31:0] RV = 32'h0000_0100;

  typedef struct {
    int          lat;
    int          ru;
    logic [31:0] pc;
    int          term;
    int          dcyc;
    bit          we;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr, pc, pc_plus4, alu_res;
  logic        branch_taken;
  logic        ru_wr, retire, halted, trap;
  logic [2:0]  state;
`ifdef MC_PERF_COUNTERS_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  int assertions = 0;
  int failures   = 0;
  logic [31:0] model_pc;

  logic [6:0] opcs [9] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                           7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111};

  multicycle_sequencer_if #(.XLEN(32)) bus ();

  multicycle_sequencer #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem          (bus),
    .instr        (instr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .alu_res      (alu_res),
    .branch_taken (branch_taken),
    .ru_wr        (ru_wr),
    .retire       (retire),
    .halted       (halted),
    .trap         (trap),
    .state        (state)
`ifdef MC_PERF_COUNTERS_EN
    ,
    .perf_cycle   (perf_cycle),
    .perf_instret (perf_instret)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Expected outcome of one instruction from the class rules: latency counts
  // cycles up to the retire pulse, or up to entry into TRAP; term 1=halt 2=trap.
  function automatic res_t model_instr(input logic [31:0] ins, input logic [31:0] alu,
                                       input bit taken, input logic [31:0] pc_in,
                                       input int iw, input int dw);
    res_t        r;
    logic [31:0] tgt;
    logic [24:0] upper;
    int          rd_nz;
    upper  = ins[31:7];
    rd_nz  = (ins[11:7] != 5'd0) ? 1 : 0;
    r.lat  = 0; r.ru = 0; r.pc = pc_in; r.term = 0; r.dcyc = 0; r.we = 1'b0;
    case (ins[6:0])
      7'b0000011: begin r.lat = iw + dw + 5; r.ru = rd_nz; r.pc = pc_in + 32'd4; r.dcyc = dw + 1; end
      7'b0100011: begin r.lat = iw + dw + 4; r.pc = pc_in + 32'd4; r.dcyc = dw + 1; r.we = 1'b1; end
      7'b1100011: begin
        r.lat = iw + 3;
        if (taken && alu[1:0] != 2'b00) r.term = 2;
        else r.pc = taken ? alu : pc_in + 32'd4;
      end
      7'b1101111, 7'b1100111: begin
        tgt   = (ins[6:0] == 7'b1100111) ? (alu & 32'hFFFF_FFFE) : alu;
        r.lat = iw + 4;
        if (tgt[1]) r.term = 2;
        else begin r.ru = rd_nz; r.pc = tgt; end
      end
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
        r.lat = iw + 4; r.ru = rd_nz; r.pc = pc_in + 32'd4;
      end
      7'b1110011: begin
        r.lat  = iw + 3;
        r.term = (upper == 25'd0 || upper == 25'h2000) ? 1 : 2;
      end
      default: begin r.lat = iw + 2; r.term = 2; end
    endcase
    return r;
  endfunction

  // Hold reset for two clocks and release it just after a rising edge.
  task automatic do_reset();
    reset = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.imem_rdata = 32'd0;
    alu_res = 32'd0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    model_pc = RV;
  endtask

  // Play memory for one instruction: imem answers after iw waits, dmem after dw
  // waits, irrelevant readies are randomised; records what the DUT did.
  task automatic apply_instr(input logic [31:0] ins, input logic [31:0] alu, input bit taken,
                             input int iw, input int dw, input logic [31:0] exp_addr,
                             output res_t o, output bit addr_bad, output bit ru_aligned);
    int cyc, iwc, dwc, ru_cyc, ret_cyc;
    bit done;
    cyc = 0; iwc = 0; dwc = 0; ru_cyc = -1; ret_cyc = -1; done = 1'b0;
    o.lat = -1; o.ru = 0; o.pc = 32'hx; o.term = 0; o.dcyc = 0; o.we = 1'b0;
    addr_bad = 1'b0;
    alu_res = alu; branch_taken = taken;
    while (!done) begin
      @(negedge clk);
      if (trap === 1'b1) begin
        done = 1'b1; o.lat = cyc; o.term = 2; o.pc = pc;
      end else if (cyc >= 60) begin
        done = 1'b1; o.lat = -1; o.pc = pc;
      end else begin
        cyc++;
        bus.imem_ready = 1'($urandom_range(0, 1));
        bus.imem_rdata = $urandom;
        bus.dmem_ready = 1'($urandom_range(0, 1));
        if (bus.imem_req === 1'b1) begin
          if (bus.imem_addr !== exp_addr) addr_bad = 1'b1;
          if (iwc == iw) begin bus.imem_ready = 1'b1; bus.imem_rdata = ins; end
          else begin bus.imem_ready = 1'b0; iwc++; end
        end
        if (bus.dmem_req === 1'b1) begin
          o.dcyc++;
          o.we = bus.dmem_we;
          if (dwc == dw) bus.dmem_ready = 1'b1;
          else begin bus.dmem_ready = 1'b0; dwc++; end
        end
        #1;
        if (ru_wr === 1'b1) begin o.ru++; ru_cyc = cyc; end
        if (retire === 1'b1) begin ret_cyc = cyc; o.lat = cyc; done = 1'b1; end
      end
    end
    if (ret_cyc > 0) begin
      @(posedge clk);
      #1;
      o.pc   = pc;
      o.term = (halted === 1'b1) ? 1 : ((trap === 1'b1) ? 2 : 0);
    end
    ru_aligned = (o.ru == 0) || (ru_cyc == ret_cyc);
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
  endtask

  // Reset values right after release.
  task automatic test_reset();
    do_reset();
    assertions++; if (pc !== RV) begin failures++; $display("[TB] FAIL reset_pc got %h expected %h", pc, RV); end
    assertions++; if (state !== 3'd0) begin failures++; $display("[TB] FAIL reset_state got %0d expected 0", state); end
    assertions++; if (bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL reset_imem_req got %b expected 1", bus.imem_req); end
    assertions++; if (instr !== 32'h0000_0013) begin failures++; $display("[TB] FAIL reset_instr got %h expected 00000013", instr); end
    assertions++; if ({ru_wr, retire, bus.dmem_req, halted, trap} !== 5'b0) begin
      failures++; $display("[TB] FAIL reset_strobes got %b expected 00000", {ru_wr, retire, bus.dmem_req, halted, trap});
    end
`ifdef MC_PERF_COUNTERS_EN
    assertions++; if ({perf_cycle, perf_instret} !== 128'd0) begin
      failures++; $display("[TB] FAIL reset_perf got %0d/%0d expected 0/0", perf_cycle, perf_instret);
    end
`endif
  endtask

  // addi x1,x0,5 with zero-wait fetch: write and retire together in cycle 4.
  task automatic test_addi();
    res_t o; bit ab, ra;
    do_reset();
    apply_instr(32'h0050_0093, 32'h0, 1'b0, 0, 0, RV, o, ab, ra);
    assertions++; if (o.lat !== 4) begin failures++; $display("[TB] FAIL addi_latency got %0d expected 4", o.lat); end
    assertions++; if (o.ru !== 1) begin failures++; $display("[TB] FAIL addi_ru_wr got %0d expected 1", o.ru); end
    assertions++; if (ra !== 1'b1) begin failures++; $display("[TB] FAIL addi_ru_with_retire got %b expected 1", ra); end
    assertions++; if (o.pc !== 32'h104) begin failures++; $display("[TB] FAIL addi_pc got %h expected 00000104", o.pc); end
  endtask

  // lw with three dmem wait cycles.
  task automatic test_load_wait();
    res_t o; bit ab, ra;
    do_reset();
    apply_instr(32'h0000_A283, 32'h40, 1'b0, 0, 3, RV, o, ab, ra);
    assertions++; if (o.dcyc !== 4) begin failures++; $display("[TB] FAIL lw_dmem_req_cycles got %0d expected 4", o.dcyc); end
    assertions++; if (o.we !== 1'b0) begin failures++; $display("[TB] FAIL lw_dmem_we got %b expected 0", o.we); end
    assertions++; if (o.lat !== 8) begin failures++; $display("[TB] FAIL lw_latency got %0d expected 8", o.lat); end
    assertions++; if (o.ru !== 1) begin failures++; $display("[TB] FAIL lw_ru_wr got %0d expected 1", o.ru); end
  endtask

  // beq taken to an aligned then a misaligned target.
  task automatic test_branch();
    res_t o; bit ab, ra;
    do_reset();
    apply_instr(32'h0000_0063, 32'h80, 1'b1, 0, 0, RV, o, ab, ra);
    assertions++; if (o.lat !== 3) begin failures++; $display("[TB] FAIL beq_latency got %0d expected 3", o.lat); end
    assertions++; if (o.pc !== 32'h80) begin failures++; $display("[TB] FAIL beq_pc got %h expected 00000080", o.pc); end
    assertions++; if (o.ru !== 0) begin failures++; $display("[TB] FAIL beq_ru_wr got %0d expected 0", o.ru); end
    apply_instr(32'h0000_0063, 32'h82, 1'b1, 0, 0, 32'h80, o, ab, ra);
    assertions++; if (o.term !== 2 || state !== 3'd6) begin
      failures++; $display("[TB] FAIL beq_misaligned_trap got term %0d state %0d expected 2/6", o.term, state);
    end
    assertions++; if (o.pc !== 32'h80) begin failures++; $display("[TB] FAIL beq_misaligned_pc got %h expected 00000080", o.pc); end
    assertions++; if (ab !== 1'b0) begin failures++; $display("[TB] FAIL beq_fetch_addr got unstable expected stable"); end
  endtask

  // Illegal opcode traps after DECODE, stays quiet, and reset recovers.
  task automatic test_illegal();
    res_t o; bit ab, ra;
    do_reset();
    apply_instr(32'h0000_007F, 32'h0, 1'b0, 1, 0, RV, o, ab, ra);
    assertions++; if (o.term !== 2 || o.lat !== 3) begin
      failures++; $display("[TB] FAIL illegal_trap got term %0d lat %0d expected 2/3", o.term, o.lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      assertions++; if (bus.imem_req !== 1'b0 || trap !== 1'b1) begin
        failures++; $display("[TB] FAIL illegal_quiet got req %b trap %b expected 0/1", bus.imem_req, trap);
      end
    end
    do_reset();
    assertions++; if (state !== 3'd0 || trap !== 1'b0 || bus.imem_req !== 1'b1) begin
      failures++; $display("[TB] FAIL illegal_recover got state %0d trap %b req %b expected 0/0/1", state, trap, bus.imem_req);
    end
  endtask

  // Reset asserted during WB must suppress the write and the retire.
  task automatic test_abort();
    do_reset();
    @(negedge clk); bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0050_0093;
    @(negedge clk); bus.imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    assertions++; if (ru_wr !== 1'b0 || retire !== 1'b0 || state !== 3'd0 || pc !== RV) begin
      failures++; $display("[TB] FAIL abort got ru %b ret %b state %0d pc %h expected 0/0/0/%h", ru_wr, retire, state, pc, RV);
    end
    do_reset();
  endtask

  // PC wrap: jump to the last word, then step past it.
  task automatic test_wrap();
    res_t o; bit ab, ra;
    do_reset();
    apply_instr(32'h0000_006F, 32'hFFFF_FFFC, 1'b0, 0, 0, RV, o, ab, ra);
    assertions++; if (o.pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      failures++; $display("[TB] FAIL wrap_jal got pc %h pc_plus4 %h expected fffffffc/00000000", o.pc, pc_plus4);
    end
    apply_instr(32'h0050_0093, 32'h0, 1'b0, 0, 0, 32'hFFFF_FFFC, o, ab, ra);
    assertions++; if (o.pc !== 32'h0 || ab !== 1'b0) begin
      failures++; $display("[TB] FAIL wrap_step got pc %h addr_bad %b expected 00000000/0", o.pc, ab);
    end
  endtask

  // Two addi then ebreak: halt with a retire pulse, counters exact then frozen.
  task automatic test_halt();
    res_t o; bit ab, ra;
    int sum_lat;
    do_reset();
    apply_instr(32'h0050_0093, 32'h0, 1'b0, 2, 0, RV, o, ab, ra);
    sum_lat = o.lat;
    apply_instr(32'h00A0_0113, 32'h0, 1'b0, 0, 0, RV + 32'd4, o, ab, ra);
    sum_lat += o.lat;
    apply_instr(32'h0010_0073, 32'h0, 1'b0, 1, 0, RV + 32'd8, o, ab, ra);
    sum_lat += o.lat;
    assertions++; if (o.lat !== 4 || o.term !== 1) begin
      failures++; $display("[TB] FAIL ebreak_retire got lat %0d term %0d expected 4/1", o.lat, o.term);
    end
    assertions++; if (halted !== 1'b1 || state !== 3'd5 || o.pc !== RV + 32'd8) begin
      failures++; $display("[TB] FAIL ebreak_halt got halted %b state %0d pc %h expected 1/5/%h", halted, state, o.pc, RV + 32'd8);
    end
`ifdef MC_PERF_COUNTERS_EN
    assertions++; if (perf_instret !== 64'd3 || perf_cycle !== 64'(sum_lat)) begin
      failures++; $display("[TB] FAIL perf_at_halt got %0d/%0d expected 3/%0d", perf_instret, perf_cycle, sum_lat);
    end
`endif
    repeat (5) @(negedge clk);
    assertions++; if (bus.imem_req !== 1'b0 || halted !== 1'b1) begin
      failures++; $display("[TB] FAIL halt_quiet got req %b halted %b expected 0/1", bus.imem_req, halted);
    end
`ifdef MC_PERF_COUNTERS_EN
    assertions++; if (perf_cycle !== 64'(sum_lat) || perf_instret !== 64'd3) begin
      failures++; $display("[TB] FAIL perf_frozen got %0d/%0d expected %0d/3", perf_cycle, perf_instret, sum_lat);
    end
`endif
  endtask

  // Random instruction stream with random wait states and distractor readies.
  task automatic test_random();
    res_t e, o; bit ab, ra;
    logic [31:0] r, ins, alu;
    logic [6:0] op;
    int k, iw, dw;
    bit taken;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      r = $urandom;
      k = $urandom_range(0, 19);
      if (k < 18) op = opcs[k % 9];
      else if (k == 18) op = 7'b1110011;
      else op = 7'b1011011;
      ins = {r[31:7], op};
      if (k == 18) begin
        case ($urandom_range(0, 2))
          0: ins = 32'h0000_0073;
          1: ins = 32'h0010_0073;
          default: ;
        endcase
      end
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      taken = 1'($urandom_range(0, 1));
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      e = model_instr(ins, alu, taken, model_pc, iw, dw);
      apply_instr(ins, alu, taken, iw, dw, model_pc, o, ab, ra);
      assertions++; if (o.lat !== e.lat) begin failures++; $display("[TB] FAIL rand%0d_latency ins %h got %0d expected %0d", i, ins, o.lat, e.lat); end
      assertions++; if (o.ru !== e.ru) begin failures++; $display("[TB] FAIL rand%0d_ru_wr ins %h got %0d expected %0d", i, ins, o.ru, e.ru); end
      assertions++; if (o.pc !== e.pc) begin failures++; $display("[TB] FAIL rand%0d_pc ins %h got %h expected %h", i, ins, o.pc, e.pc); end
      assertions++; if (o.term !== e.term) begin failures++; $display("[TB] FAIL rand%0d_term ins %h got %0d expected %0d", i, ins, o.term, e.term); end
      assertions++; if (o.dcyc !== e.dcyc) begin failures++; $display("[TB] FAIL rand%0d_dmem_cycles ins %h got %0d expected %0d", i, ins, o.dcyc, e.dcyc); end
      if (e.dcyc > 0) begin
        assertions++; if (o.we !== e.we) begin failures++; $display("[TB] FAIL rand%0d_dmem_we ins %h got %b expected %b", i, ins, o.we, e.we); end
      end
      assertions++; if (ab !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_fetch_addr got unstable expected %h", i, model_pc); end
      assertions++; if (ra !== 1'b1) begin failures++; $display("[TB] FAIL rand%0d_ru_with_retire got %b expected 1", i, ra); end
      if (e.term != 0) do_reset();
      else model_pc = e.pc;
    end
  endtask

  // Run every scenario in turn, then report.
  initial begin
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.imem_rdata = 32'd0;
    alu_res = 32'd0; branch_taken = 1'b0; model_pc = RV;
    test_reset();
    test_addi();
    test_load_wait();
    test_branch();
    test_illegal();
    test_abort();
    test_wrap();
    test_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired after %0d assertions", assertions);
    $fatal(1, "[TB] watchdog");
  end

endmodule
